// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding, sync byte and error codes for the UART image loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM} state_t;
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SIZE    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;
endpackage

// File: rtl/imem_loader_word_pack.sv
// imem_loader_word_pack: packs four bytes (LSB first) into a 32-bit word and strobes on the 4th byte.
module imem_loader_word_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);
    logic [1:0]  lane;
    logic [23:0] acc;

    // The top byte is never stored: it is taken straight from the input on the completing cycle.
    assign word      = {byte_data, acc};
    assign word_done = byte_valid && lane == 2'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= 2'd0;
            acc  <= 24'd0;
        end else if (clear) begin
            lane <= 2'd0;
        end else if (byte_valid) begin
            lane <= lane + 2'd1;
            if (lane != 2'd3) acc[{lane, 3'b000} +: 8] <= byte_data;
        end
    end
endmodule

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: parses framed UART load images into instruction memory writes and holds the core meanwhile.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        imem_we,
    output logic [31:0] imem_a,
    output logic [31:0] imem_wd,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    logic [15:0]   cnt;
    logic [15:0]   widx;
    logic [TW-1:0] tmo;
    logic [31:0]   word;
    logic          word_done;
    logic [15:0]   n;
    logic          last_word;
    logic          expired;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    imem_loader_word_pack u_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state != S_DATA),
        .byte_valid(rx_valid && state == S_DATA),
        .byte_data (rx_data),
        .word      (word),
        .word_done (word_done)
    );

    assign n         = {rx_data, cnt[7:0]};
    assign last_word = word_done && (widx + 16'd1 == cnt);
    // An arriving byte always beats a simultaneous expiry.
    assign expired   = busy && !rx_valid && (tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 16'd0;
            widx      <= 16'd0;
            tmo       <= '0;
            imem_we   <= 1'b0;
            imem_a    <= 32'd0;
            imem_wd   <= 32'd0;
            core_hold <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= ERR_NONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            tmo     <= (busy && !rx_valid) ? tmo + 1'b1 : '0;
            if (word_done) begin
                imem_we <= 1'b1;
                imem_a  <= {14'd0, widx, 2'b00};
                imem_wd <= word;
                widx    <= widx + 16'd1;
            end
            if (expired) begin
                err   <= ERR_TIMEOUT;
                busy  <= 1'b0;
                state <= S_IDLE;
            end else if (rx_valid) begin
                case (state)
                    S_IDLE: if (rx_data == SYNC_BYTE) begin
                        done      <= 1'b0;
                        err       <= ERR_NONE;
                        busy      <= 1'b1;
                        core_hold <= 1'b1;
                        widx      <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum      <= 8'd0;
`endif
                        state     <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        cnt[7:0] <= rx_data;
                        state    <= S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        cnt[15:8] <= rx_data;
                        if ({16'd0, n} > 32'(MEM_WORDS)) begin
                            err   <= ERR_SIZE;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            core_hold <= 1'b0;
                            state     <= S_IDLE;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum + rx_data;
                        if (last_word) state <= S_CSUM;
`else
                        if (last_word) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            core_hold <= 1'b0;
                            state     <= S_IDLE;
                        end
`endif
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (rx_data == csum) begin
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            err <= ERR_CSUM;
                        end
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
